// File: rtl/uncache_unit_pkg.sv
// Shared types for the uncached access unit: FSM state codes, bus size codes,
// the latched request record and the core-wen to bus-size mapping.
package uncache_unit_pkg;

    localparam int UC_AW = 32;
    localparam int UC_DW = 32;

    typedef enum logic [1:0] {
        UC_IDLE = 2'd0,
        UC_REQ  = 2'd1,
        UC_WAIT = 2'd2,
        UC_DONE = 2'd3
    } uc_state_e;

    localparam logic [1:0] UC_SIZE_B = 2'd0;
    localparam logic [1:0] UC_SIZE_H = 2'd1;
    localparam logic [1:0] UC_SIZE_W = 2'd2;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic [UC_AW-1:0] addr;
        logic [3:0]       wstrb;
        logic [UC_DW-1:0] wdata;
    } uc_req_t;

    // Loads (wen==0) fall into the word default: the core picks its lanes itself.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return UC_SIZE_B;
            4'b0011, 4'b1100:                   return UC_SIZE_H;
            default:                            return UC_SIZE_W;
        endcase
    endfunction

    function automatic uc_req_t make_req(input logic [3:0]       wen,
                                         input logic [UC_AW-1:0] addr,
                                         input logic [UC_DW-1:0] wdata);
        uc_req_t r;
        r.wr    = |wen;
        r.size  = wen_to_size(wen);
        r.addr  = r.wr ? addr : {addr[UC_AW-1:2], 2'b00};
        r.wstrb = wen;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/uncache_unit_if.sv
// SRAM-like uncached bus: one request per addr_ok handshake, one response per data_ok.
interface uncache_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [3:0]    wstrb;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/uncache_unit_wbuf.sv
// One-entry posted store buffer: holds a store while it drains on the bus.
module uncache_unit_wbuf
    import uncache_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  uc_req_t din,
    output logic    valid,
    output uc_req_t dout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uncache_unit.sv
// Uncached load/store unit: turns one core data access into one bus transaction.
// Define UNCACHE_WBUF_EN to post stores through a one-entry write buffer.
module uncache_unit
    import uncache_unit_pkg::*;
#(
    parameter int AW = UC_AW,
    parameter int DW = UC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          uncached,
    input  logic          data_sram_en,
    input  logic [3:0]    data_sram_wen,
    input  logic [AW-1:0] data_sram_addr,
    input  logic [DW-1:0] data_sram_wdata,
    output logic [DW-1:0] data_sram_rdata,
    output logic          stallreq_uncache,
    uncache_unit_if.master bus
);

    uc_state_e     state;
    uc_req_t       req_q;
    uc_req_t       new_req;
    uc_req_t       issue;
    logic          bus_req_q;
    logic [DW-1:0] rdata_q;
    logic          hit;
    logic          accept;
    logic          busy;
    logic          rsp;
    logic          posted_accept;
    logic          posted_busy;

    assign hit     = data_sram_en & uncached & ~flush;
    assign accept  = (state == UC_IDLE) & hit;
    assign busy    = (state == UC_REQ) | (state == UC_WAIT);
    assign new_req = make_req(data_sram_wen, data_sram_addr, data_sram_wdata);
    // A response in REQ only counts once the request itself is taken.
    assign rsp     = bus.data_ok & ((state == UC_WAIT) | ((state == UC_REQ) & bus.addr_ok));

`ifdef UNCACHE_WBUF_EN
    logic    wb_valid;
    uc_req_t wb_entry;

    assign posted_accept = accept & new_req.wr & ~wb_valid;
    assign posted_busy   = wb_valid;
    assign issue         = wb_valid ? wb_entry : req_q;

    uncache_unit_wbuf u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (posted_accept),
        .pop   (rsp & wb_valid),
        .din   (new_req),
        .valid (wb_valid),
        .dout  (wb_entry)
    );
`else
    assign posted_accept = 1'b0;
    assign posted_busy   = 1'b0;
    assign issue         = req_q;
`endif

    // While a posted store drains the core runs free until it presents another hit.
    assign stallreq_uncache = (accept & ~posted_accept) | (busy & (~posted_busy | hit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UC_IDLE;
            req_q     <= '0;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                UC_IDLE: begin
                    if (accept) begin
                        state     <= UC_REQ;
                        bus_req_q <= 1'b1;
                        if (!posted_accept) req_q <= new_req;
                    end
                end
                UC_REQ: begin
                    if (bus.addr_ok) begin
                        bus_req_q <= 1'b0;
                        if (bus.data_ok) state <= posted_busy ? UC_IDLE : UC_DONE;
                        else             state <= UC_WAIT;
                    end
                end
                UC_WAIT: begin
                    if (bus.data_ok) state <= posted_busy ? UC_IDLE : UC_DONE;
                end
                UC_DONE: state <= UC_IDLE;
                default: state <= UC_IDLE;
            endcase
            if (rsp && !issue.wr) rdata_q <= bus.rdata;
        end
    end

    assign bus.req         = bus_req_q;
    assign bus.wr          = issue.wr;
    assign bus.size        = issue.size;
    assign bus.addr        = issue.addr;
    assign bus.wstrb       = issue.wstrb;
    assign bus.wdata       = issue.wdata;
    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_uncache_unit.sv
// Directed bench for uncache_unit: a per-transaction timeline model checked every cycle.
module tb_uncache_unit;

`ifdef UNCACHE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        uncached;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_o;
    logic        stall;

    uncache_unit_if bus_if ();

    uncache_unit dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .uncached         (uncached),
        .data_sram_en     (en),
        .data_sram_wen    (wen),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata_o),
        .stallreq_uncache (stall),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model of the current access: cycle index k counts from the accept cycle.
    int          k = -1;
    bit          cmp_en = 1'b1;
    bit          t_hit, posted;
    logic [3:0]  t_wen;
    logic [31:0] t_addr, t_wdata;
    int          t_a, t_d;
    logic [31:0] mdl_rdata = '0;

    int          stall_cnt, req_bursts;
    logic        prev_req = 1'b0;
    logic [1:0]  seen_size;
    logic [3:0]  seen_wstrb;
    logic        exp_stall, exp_req;

    function automatic logic [1:0] exp_size(input logic [3:0] w);
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        if (w == 4'b0001 || w == 4'b0010 || w == 4'b0100 || w == 4'b1000) return 2'd0;
        return 2'd2;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            if (k >= 0 && t_hit) begin
                exp_req   = (k >= 1) && (k <= 1 + t_a);
                exp_stall = posted ? 1'b0 : (k <= 1 + t_a + t_d);
            end
            check("stall", stall, exp_stall);
            check("bus_req", bus_if.req, exp_req);
            if (exp_req && bus_if.req) begin
                check("bus_wr", bus_if.wr, |t_wen);
                check("bus_size", bus_if.size, exp_size(t_wen));
                check("bus_addr", bus_if.addr, (t_wen == 4'b0) ? {t_addr[31:2], 2'b00} : t_addr);
                check("bus_wstrb", bus_if.wstrb, t_wen);
                if (|t_wen) check("bus_wdata", bus_if.wdata, t_wdata);
            end
            check("rdata", rdata_o, mdl_rdata);
            if (k >= 0 && stall) stall_cnt++;
            if (bus_if.req && !prev_req) req_bursts++;
            if (bus_if.req) begin
                seen_size  = bus_if.size;
                seen_wstrb = bus_if.wstrb;
            end
            prev_req = bus_if.req;
        end
    end

    // Acts as the core and the bus slave; a = REQ cycles before addr_ok,
    // d = cycles from addr_ok to data_ok, fl_k = cycle carrying flush (0 = whole access).
    task automatic run(input logic [3:0] w, input logic [31:0] a_in, input logic [31:0] wd,
                       input logic [31:0] rd, input int a, input int d, input int fl_k,
                       input bit unc);
        int last;
        t_wen = w; t_addr = a_in; t_wdata = wd; t_a = a; t_d = d;
        t_hit  = unc && (fl_k != 0);
        posted = WBUF && (w != 4'b0);
        last   = !t_hit ? 2 : (posted ? 1 + a + d : 2 + a + d);
        stall_cnt = 0; req_bursts = 0;
        for (int c = 0; c <= last; c++) begin
            k        = c;
            en       = !(posted && c >= 1);
            uncached = unc;
            wen      = w; addr = a_in; wdata = wd;
            flush    = (fl_k == 0) ? 1'b1 : (c == fl_k);
            bus_if.addr_ok = t_hit && (c == 1 + a);
            bus_if.data_ok = t_hit && (c == 1 + a + d);
            bus_if.rdata   = bus_if.data_ok ? rd : $urandom;
            @(posedge clk); #1;
            if (bus_if.data_ok && w == 4'b0) mdl_rdata = rd;
        end
        k = -1; en = 1'b0; flush = 1'b0;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; uncached = 1'b0; en = 1'b0;
        wen = '0; addr = '0; wdata = '0;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_addr", bus_if.addr, 0);
        check("rst_bus_wr", bus_if.wr, 0);
        check("rst_bus_size", bus_if.size, 0);
        check("rst_bus_wstrb", bus_if.wstrb, 0);
        check("rst_bus_wdata", bus_if.wdata, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Load with waits on both handshakes.
        run(4'b0000, 32'hBFAF_8004, 32'h0, 32'h1234_5678, 1, 2, -1, 1'b1);
        check("t1_stall_cycles", stall_cnt, 5);
        check("t1_bursts", req_bursts, 1);
        check("t1_rdata", rdata_o, 32'h1234_5678);

        // Word store.
        run(4'b1111, 32'hBFAF_F000, 32'hDEAD_BEEF, 32'h0, 0, 1, -1, 1'b1);
        check("t2_size", seen_size, 2);
`ifndef UNCACHE_WBUF_EN
        check("t2_stall_cycles", stall_cnt, 3);
`endif

        // Byte and half stores.
        run(4'b0100, 32'hBFAF_F002, 32'h00AB_0000, 32'h0, 2, 1, -1, 1'b1);
        check("t3_sb_size", seen_size, 0);
        check("t3_sb_wstrb", seen_wstrb, 4'b0100);
        run(4'b1100, 32'hBFAF_F002, 32'hBEEF_0000, 32'h0, 0, 0, -1, 1'b1);
        check("t3_sh_size", seen_size, 1);

        // Unaligned load address, both handshakes in the REQ cycle.
        run(4'b0000, 32'hBFAF_8006, 32'h0, 32'hA5A5_5A5A, 0, 0, -1, 1'b1);
        check("t4_stall_cycles", stall_cnt, 2);
        check("t4_rdata", rdata_o, 32'hA5A5_5A5A);

        // Flush in IDLE, non-uncached access, flush during WAIT.
        run(4'b0000, 32'hBFAF_8008, 32'h0, 32'h1111_1111, 0, 0, 0, 1'b1);
        check("t5_flush_bursts", req_bursts, 0);
        run(4'b0000, 32'h8000_0000, 32'h0, 32'h2222_2222, 0, 0, -1, 1'b0);
        check("t5_cached_bursts", req_bursts, 0);
        run(4'b0000, 32'hBFAF_800C, 32'h0, 32'hCAFE_F00D, 0, 3, 2, 1'b1);
        check("t5_wait_flush_bursts", req_bursts, 1);
        check("t5_wait_flush_rdata", rdata_o, 32'hCAFE_F00D);

        // Reset asserted while waiting for data_ok.
        cmp_en = 1'b0;
        en = 1'b1; uncached = 1'b1; wen = 4'b0; addr = 32'hBFAF_8010;
        @(posedge clk); #1;
        bus_if.addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_if.addr_ok = 1'b0;
        #1 check("t6_wait_stall", stall, 1);
        #1 rst = 1'b0; en = 1'b0;
        #1 check("t6_rst_req", bus_if.req, 0);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_rdata", rdata_o, 0);
        mdl_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus_if.data_ok = 1'b1; bus_if.rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus_if.data_ok = 1'b0;
        check("t6_stale_rsp_ignored", rdata_o, 0);
        prev_req = 1'b0;
        cmp_en = 1'b1;
        run(4'b0000, 32'hBFAF_8014, 32'h0, 32'h0BAD_F00D, 1, 1, -1, 1'b1);
        check("t6_recover_rdata", rdata_o, 32'h0BAD_F00D);

`ifdef UNCACHE_WBUF_EN
        // Posted store followed by a load that must wait for the store's data_ok.
        cmp_en = 1'b0;
        en = 1'b1; uncached = 1'b1; wen = 4'b1111; addr = 32'hBFAF_F010; wdata = 32'h7777_8888;
        #1 check("wb_store_stall", stall, 0);
        @(posedge clk); #1;
        wen = 4'b0; addr = 32'hBFAF_8020; bus_if.addr_ok = 1'b1;
        #1 check("wb_load_stall_req", stall, 1);
        check("wb_store_wr", bus_if.wr, 1);
        @(posedge clk); #1;
        bus_if.addr_ok = 1'b0;
        #1 check("wb_load_stall_wait", stall, 1);
        @(posedge clk); #1;
        bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0;
        #1 check("wb_load_stall_dok", stall, 1);
        @(posedge clk); #1;
        bus_if.data_ok = 1'b0;
        #1 check("wb_load_accept_stall", stall, 1);
        check("wb_load_accept_req", bus_if.req, 0);
        @(posedge clk); #1;
        check("wb_load_req", bus_if.req, 1);
        check("wb_load_wr", bus_if.wr, 0);
        bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h3C3C_C3C3;
        @(posedge clk); #1;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
        check("wb_load_done_stall", stall, 0);
        check("wb_load_rdata", rdata_o, 32'h3C3C_C3C3);
        mdl_rdata = 32'h3C3C_C3C3;
        @(posedge clk); #1;
        en = 1'b0;
        prev_req = 1'b0;
        cmp_en = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
